dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's MEM-stage load/store requests over a valid/ready request/response handshake.
- Adds a configurable wait-state latency, per-byte write enables, and error reporting for misaligned or out-of-range word addresses.
- Replaces the zero-wait data memory so the pipeline can be exercised against a slow memory that forces stalls.
- The word array is internal and synchronous; there is one outstanding request at a time.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
LATENCY, 2, cycles from request-accept edge to response-valid edge; legal range 1..15
IDX_W, 8, word-index width, equal to clog2(DEPTH_WORDS)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low
req_valid  input  1  CPU presents a request
req_ready  output  1  responder can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte-lane write enables; bit i controls bits [8i+7:8i]; ignored for loads
resp_valid  output  1  response available
resp_ready  input  1  CPU accepts response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  request was misaligned or out of range
busy  output  1  high in WAIT or RESP

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE and the wait counter clears.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - req_ready=1 from the first cycle after reset deasserts.
  - Memory array contents are not cleared and are unaffected by reset.
  - Reset in WAIT or RESP aborts the request. A pending store is not performed and no response is produced.
- FSM, three states:
  - IDLE:
    - req_ready=1.
    - On an edge with req_valid=1, latch req_we, req_addr, req_wdata and req_be, load the counter with LATENCY-1, and go to WAIT.
    - Request inputs are ignored in every other state.
  - WAIT:
    - busy=1, req_ready=0.
    - If counter != 0, decrement it.
    - If counter == 0 at an edge, perform the access and go to RESP.
  - RESP:
    - resp_valid=1, busy=1.
    - On an edge with resp_ready=1, clear resp_valid, resp_rdata and resp_err, and return to IDLE.
    - Hold the response indefinitely while resp_ready=0.
- Latency:
  - Accept at edge T; resp_valid first high in the cycle after edge T+LATENCY.
  - The earliest next accept is the edge after the response handshake, so back-to-back throughput is LATENCY+2 cycles per request.
- Access rules at the perform edge:
  - Error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS. Then resp_err=1, resp_rdata=0, and memory is unchanged.
  - Load: resp_rdata = mem[addr[IDX_W+1:2]].
  - Store: each byte lane with be[i]=1 is written and other lanes are kept; resp_rdata=0, resp_err=0. A store with be=0 completes normally with no change.
  - A load issued after a store to the same word returns the updated data.
- resp_rdata and resp_err are registered and stable for the whole RESP state.
- A request held on req_valid during WAIT/RESP is not accepted until IDLE. The CPU must keep it stable, and the responder never samples it early.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, LATENCY=2, resp_ready=1 -> req_ready drops the cycle after accept; resp_valid rises 2 edges after accept with resp_err=0, resp_rdata=0. A following load of 0x10 returns 0xDEADBEEF.
- Byte-enable store to 0x10 with wdata=0x00000055, be=4'b0001 -> a later load returns 0xDEADBE55. A store with be=0 leaves the word unchanged.
- Load addr=0x12 (misaligned), and separately load addr=4*DEPTH_WORDS -> each gives resp_err=1, resp_rdata=0. An erroring store to 0x402 does not alter any word.
- Backpressure: resp_ready held low 5 cycles after resp_valid -> resp_valid, rdata and err stay stable and req_ready stays 0. Raising resp_ready causes a return to IDLE on that edge, with req_ready=1 the next cycle.
- Reset asserted (low) during WAIT of a store to 0x20 -> the next cycle shows IDLE, resp_valid=0, busy=0. A later load of 0x20 returns the pre-store value; no response is ever emitted for the aborted request.
- LATENCY=1 with 4 back-to-back loads, req_valid held high, resp_ready=1 -> exactly one response per request in order, spaced 3 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage loads/stores: one outstanding request,
// LATENCY-cycle wait state, per-byte store enables, misalign/range errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int IDX_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;

  logic             w_accept, w_perform, w_handshake, w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_perform   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_handshake = (r_state == S_RESP) && resp_ready;
  assign w_idx       = r_addr[IDX_W+1:2];
  assign w_err       = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH_WORDS));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)   w_next = S_WAIT;
      S_WAIT:  if (w_perform)   w_next = S_RESP;
      S_RESP:  if (resp_ready)  w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    busy       = (r_state == S_WAIT) || (r_state == S_RESP);
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Request latch, wait counter and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_perform) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'h0 : w_rd;
      end else if (w_handshake) begin
        r_err   <= 1'b0;
        r_rdata <= 32'h0;
      end
    end
  end

  // Storage split into byte lanes so each enable owns its own array;
  // never reset, and writes are suppressed while reset is asserted.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_bytes [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (reset && w_perform && r_we && !w_err && r_be[g])
        r_bytes[w_idx] <= r_wdata[8*g +: 8];
    end

    assign w_rd[8*g +: 8] = r_bytes[w_idx];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, backpressure,
// reset abort, randomized traffic against an array model, LATENCY=1 streaming.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid1;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        req_ready1, resp_valid1, resp_err1, busy1;
  logic [31:0] resp_rdata1;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .IDX_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .IDX_W(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the access rules.
  task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd, output logic err);
    int unsigned idx;
    idx = addr / 4;
    err = (addr % 4 != 0) || (idx >= DEPTH);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = model_mem[idx];
      end
    end
  endtask

  // One request on the LATENCY=2 instance; called at a negedge with the DUT idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int stall,
                     output logic [31:0] rd, output logic err);
    int n;
    chk("idle_ready", {busy, req_ready}, 2'b01);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    resp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_drop", {busy, req_ready, resp_valid}, 3'b100);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);
    rd = resp_rdata; err = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold", {resp_valid, req_ready, busy, resp_err, resp_rdata}, {3'b101, err, rd});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("return", {resp_valid, busy, req_ready, resp_err, resp_rdata}, {4'b0010, 32'h0});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  // Streams four requests with req_valid held high into the LATENCY=1 instance.
  task automatic b2b(input logic we);
    logic [31:0] got[$];
    int          at[$];
    int          item;
    bit          adv;
    item = 0; adv = 0;
    req_we = we; req_addr = 32'h0; req_wdata = 32'h77000000; req_be = 4'hF;
    resp_ready = 1'b1; req_valid1 = 1'b1;
    for (int k = 0; k < 40 && got.size() < 4; k++) begin
      if (req_valid1 && req_ready1) adv = 1;
      @(negedge clk);
      if (resp_valid1) begin
        got.push_back(resp_rdata1);
        at.push_back(k);
        chk("b2b_err", resp_err1, 1'b0);
      end
      if (adv) begin
        adv = 0;
        item++;
        if (item < 4) begin
          req_addr  = 32'(item * 4);
          req_wdata = 32'h77000000 + 32'(item) * 32'h11;
        end else begin
          req_valid1 = 1'b0;
        end
      end
    end
    req_valid1 = 1'b0;
    chk("b2b_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) begin
      chk("b2b_data", got[i], we ? 32'h0 : 32'h77000000 + 32'(i) * 32'h11);
      if (i > 0) chk("b2b_spacing", at[i] - at[i-1], 3);
    end
    repeat (4) begin
      @(negedge clk);
      chk("b2b_extra", resp_valid1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, a;
    logic        err, eerr;
    int          cnt;

    reset = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs",  {resp_valid, busy, resp_err, resp_rdata}, 35'h0);
    chk("rst_outs1", {resp_valid1, busy1, resp_err1, resp_rdata1}, 35'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {req_ready, req_ready1}, 2'b11);

    // Known contents for every word
    for (int i = 0; i < DEPTH; i++) begin
      model_apply(1'b1, 32'(i * 4), 32'h5A000000 | 32'(i), 4'hF, erd, eerr);
      txn(1'b1, 32'(i * 4), 32'h5A000000 | 32'(i), 4'hF, 0, rd, err);
    end
    chk("prefill_resp", {err, rd}, 33'h0);

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h00000055, 4'h1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBE55, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBE55, 1'b0};
    vecs[6]  = '{1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h402, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h5A000000, 1'b0};
    vecs[10] = '{1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0};
    vecs[12] = '{1'b1, 32'h24,  32'h11223344, 4'hA, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h24,  32'h0,        4'h0, 32'h11003309, 1'b0};
    for (int i = 0; i < 14; i++) begin
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, erd, eerr);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, err);
      chk($sformatf("vec%0d", i), {err, rd}, {vecs[i].exp_err, vecs[i].exp_rd});
    end

    // Backpressure: response held five extra cycles
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, err);
    chk("bp_data", {err, rd}, {1'b0, 32'hDEADBE55});

    // Reset during WAIT of a store aborts it
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {resp_valid, busy, resp_err, resp_rdata}, 35'h0);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("abort_noresp", cnt, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err);
    chk("abort_mem", {err, rd}, {1'b0, 32'h5A000008});

    // Randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      int          sel, stall;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (sel == 1) begin a = $urandom; if (a < 32'h400) a = a + 32'h400; end
      else               a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      model_apply(we, a, wd, be, erd, eerr);
      txn(we, a, wd, be, stall, rd, err);
      chk("rand", {err, rd}, {eerr, erd});
    end

    // LATENCY=1 streaming: stores then loads
    b2b(1'b1);
    b2b(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
